uart_rx_param: RTL and testbench

- Parametrised next-generation UART receiver for the board interface; replaces the fixed 8N1 receiver in the image-proc input path.
- Adds configurable data width, parity and stop bits, input synchronisation with majority-vote sampling, and error reporting.
- Delivers one data word per frame with a single-cycle valid strobe to the downstream command/pixel parser.

---
 rtl/uart_rx_param_pkg.sv | 26 ++
 rtl/uart_rx_sync_filter.sv | 35 +++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver (and its transmitter
// successor): FSM state encoding, parity-mode constants and a helper for the
// mid-bit sample point.
package uart_rx_param_pkg;

  // 3-bit state encoding; also exported on the receiver's debug state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Count at which the start bit is re-checked (middle of the bit period).
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// Input conditioning for the UART receiver.
// A metastability flop feeds a 3-deep tap shift register. taps[0] is the
// second synchroniser flop, so the first tap lags the line by two flops.
// The vote output is the majority of the three taps and rejects single-cycle
// spikes. All flops preset to 1 (line idle) on reset.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_data       : raw asynchronous serial line
//   o_first      : first tap (synchronised line, 2 flops of latency)
//   o_vote       : majority of the three taps
module uart_rx_sync_filter (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  output logic o_first,
  output logic o_vote
);

  logic       meta;
  logic [2:0] taps;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b1;
      taps <= 3'b111;
    end else begin
      meta <= i_data;
      taps <= {taps[1:0], meta};
    end
  end

  assign o_first = taps[0];
  assign o_vote  = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// Frame: start bit, DATA_BITS payload bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Every bit is sampled at its middle using the
// majority-filtered line value.
// Output handshake: o_valid is a one-cycle strobe with no back-pressure; the
// downstream parser must capture o_data/o_parity_err/o_frame_err in the strobe
// cycle. Those outputs are registered together with o_valid and hold their
// value until the next strobe.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_data         : asynchronous serial line, idles high
//   o_valid        : frame-complete strobe
//   o_data         : last received word
//   o_parity_err   : parity error of the strobed frame
//   o_frame_err    : a stop bit of the strobed frame was low
//   o_busy         : receiver not idle
//   o_state        : current FSM state (debug)
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 127,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_data,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_rx_param: illegal parameter set");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic first_tap, s;

  uart_rx_sync_filter u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .o_first(first_tap),
    .o_vote (s)
  );

  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 valid_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 perr_out_n, ferr_out_n;
  logic                 ferr_now;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      stop_idx     <= stop_idx_n;
      shreg        <= shreg_n;
      perr         <= perr_n;
      ferr         <= ferr_n;
      o_valid      <= valid_n;
      o_data       <= data_n;
      o_parity_err <= perr_out_n;
      o_frame_err  <= ferr_out_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    valid_n    = 1'b0;
    data_n     = o_data;
    perr_out_n = o_parity_err;
    ferr_out_n = o_frame_err;
    ferr_now   = ferr | ~s;
    case (state)
      ST_IDLE: begin
        if (!first_tap) begin
          state_n = ST_START;
          cnt_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          // A start bit that is high again at mid-bit was a glitch.
          if (!s) begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = s;
          if (bit_idx == IDX_LAST) begin
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
            state_n    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n      = '0;
          perr_n     = ((^shreg) ^ s) != (PARITY == PAR_ODD);
          stop_idx_n = 1'b0;
          state_n    = ST_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n  = '0;
          ferr_n = ferr_now;
          if ((STOP_BITS == 2) && (stop_idx == 1'b0)) begin
            stop_idx_n = 1'b1;
          end else begin
            // Leaving at mid-stop keeps a back-to-back start bit on time.
            valid_n    = 1'b1;
            data_n     = shreg;
            perr_out_n = perr;
            ferr_out_n = ferr_now;
            state_n    = s ? ST_IDLE : ST_BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_BREAK: begin
        // A held-low line must go high before another frame is accepted.
        if (first_tap) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  import uart_rx_param_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int W    = 45; // {inst[1:0], cycle[31:0], ferr, perr, data[8:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs: 8N1, 8E1, 7O2 ----------------
  logic [2:0] line;
  logic [2:0] valid, busy, perr, ferr;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] st0, st1, st2;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data(line[0]), .o_valid(valid[0]), .o_data(d0),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_busy(busy[0]), .o_state(st0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_data(line[1]), .o_valid(valid[1]), .o_data(d1),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_busy(busy[1]), .o_state(st1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_clk(clk), .i_rst(rst), .i_data(line[2]), .o_valid(valid[2]), .o_data(d2),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_busy(busy[2]), .o_state(st2));

  function automatic int cfg_db(input int k);
    return (k == 2) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic int cfg_sb(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic hold_bit(input int k, input logic v);
    line[k] = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    line = 3'b111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: parity bit chosen so the ones-count rule holds, then
  // optionally inverted; strobe time from the frame length.
  task automatic send_frame(input int k, input logic [8:0] data, input bit flip_par,
                            input logic [1:0] stops, input bit expect_it);
    int   nb, p, sb, ones, exp_cyc;
    logic par_bit, exp_perr, exp_ferr;
    nb = cfg_db(k);
    sb = cfg_sb(k);
    p  = (cfg_par(k) != 0) ? 1 : 0;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    if (cfg_par(k) == 1) par_bit = ((ones % 2) == 0);
    else                 par_bit = ((ones % 2) == 1);
    if (flip_par) par_bit = ~par_bit;
    exp_perr = (p == 1) && flip_par;
    exp_ferr = 1'b0;
    for (int i = 0; i < sb; i++) if (!stops[i]) exp_ferr = 1'b1;
    exp_cyc = cyc + 1 + 3 + HALF + CPB * (nb + p + sb);
    if (expect_it) exp_q.push_back({2'(k), 32'(exp_cyc), exp_ferr, exp_perr, data});
    hold_bit(k, 1'b0);
    for (int i = 0; i < nb; i++) hold_bit(k, data[i]);
    if (p == 1) hold_bit(k, par_bit);
    for (int i = 0; i < sb; i++) hold_bit(k, stops[i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid[k]) begin
        logic [W-1:0] e, g;
        logic [8:0]   gd;
        gd = (k == 0) ? {1'b0, d0} : ((k == 1) ? {1'b0, d1} : {2'b00, d2});
        g  = {2'(k), 32'(cyc), ferr[k], perr[k], gd};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL strobe_unexpected inst=%0d: got data=%h cyc=%0d, expected no strobe",
                   k, gd, cyc);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            mismatched++;
            $display("FAIL strobe inst=%0d: got inst=%0d cyc=%0d ferr=%0d perr=%0d data=%h, expected inst=%0d cyc=%0d ferr=%0d perr=%0d data=%h",
                     k, g[44:43], g[42:11], g[10], g[9], g[8:0],
                     e[44:43], e[42:11], e[10], e[9], e[8:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int bc;

  initial begin
    rst  = 1'b1;
    line = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_flags", int'({perr, ferr}), 0);
    check("reset_data", int'({d0, d1, d2}), 0);
    rst = 1'b0;
    idle(5);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
    idle(10);

    // 8E1 0x07 with correct then inverted parity bit
    send_frame(1, 9'h007, 1'b0, 2'b11, 1'b1);
    idle(10);
    send_frame(1, 9'h007, 1'b1, 2'b11, 1'b1);
    idle(10);

    // Glitch: 4 cycles low
    fork
      begin
        line[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line[0] = 1'b1;
      end
      begin
        bc = 0;
        repeat (40) @(negedge clk) if (busy[0]) bc++;
      end
    join
    check("glitch_busy_cycles", bc, HALF + 1);
    idle(10);

    // Break: stop bit low, line held low for 40 bit times
    send_frame(0, 9'h03C, 1'b0, 2'b10, 1'b1);
    for (int j = 0; j < 10; j++) begin
      repeat (64) @(posedge clk);
      #1;
      check("break_hold_state", int'(st0), int'(ST_BREAK));
    end
    idle(20);
    check("break_release_state", int'(st0), int'(ST_IDLE));

    // 7O2 back-to-back
    send_frame(2, 9'h055, 1'b0, 2'b11, 1'b1);
    send_frame(2, 9'h02A, 1'b0, 2'b11, 1'b1);
    idle(20);

    // Asynchronous reset during DATA bit 3
    hold_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) hold_bit(0, 1'b1);
    line[0] = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_valid", int'(valid[0]), 0);
    check("midreset_data", int'(d0), 0);
    check("midreset_flags", int'({perr[0], ferr[0]}), 0);
    check("midreset_busy", int'(busy[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b1);
    idle(10);

    // Randomised frames on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        logic [8:0] dat;
        bit         flip;
        logic [1:0] stops;
        int         gap;
        dat   = 9'($urandom_range(0, (1 << cfg_db(k)) - 1));
        flip  = (cfg_par(k) != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
        stops = (k == 2) ? {1'b1, 1'($urandom_range(0, 3) != 0)} : 2'b11;
        send_frame(k, dat, flip, stops, 1'b1);
        gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
        if (gap > 0) idle(gap);
      end
      idle(10);
    end

    // Drain: every expected strobe must have arrived
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL strobe_missing: got no strobe, expected inst=%0d data=%h at cyc=%0d",
               e[44:43], e[8:0], e[42:11]);
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
